// File: rtl/rv32i_imm_pkg.sv
// Shared definitions for the pipelined RV32I immediate generator:
// opcodes, per-lane format codes, lane bound and buffer FSM states.
package rv32i_imm_pkg;

  // Upper bound on instructions per bundle
  localparam int unsigned MaxLanes = 4;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpOp      = 7'b0110011;

  // Immediate format codes presented on out_fmt
  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtCsr  = 3'd6
  } fmt_e;

  // Output buffer occupancy
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/rv32i_imm_lane.sv
// Combinational single-lane RV32I immediate decoder.
// IMM_GEN_CSR_EN: when defined, SYSTEM with funct3[2]=1 decodes as CSR (zimm in rs1 field).
module rv32i_imm_lane (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [31:0] imm,
  output logic [2:0]  fmt,
  output logic        illegal,
  output logic [31:0] target
);
  import rv32i_imm_pkg::*;

  logic pc_rel;

  // Opcode decode to immediate, format, legality and target selection
  always_comb begin
    imm     = '0;
    fmt     = FmtNone;
    illegal = 1'b0;
    pc_rel  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OpImm, OpLoad, OpJalr, OpMiscMem: begin
          imm = {{20{instr[31]}}, instr[31:20]};
          fmt = FmtI;
        end
        OpSystem: begin
`ifdef IMM_GEN_CSR_EN
          if (instr[14]) begin
            imm = {27'b0, instr[19:15]};
            fmt = FmtCsr;
          end else begin
            imm = {{20{instr[31]}}, instr[31:20]};
            fmt = FmtI;
          end
`else
          imm = {{20{instr[31]}}, instr[31:20]};
          fmt = FmtI;
`endif
        end
        OpStore: begin
          imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          fmt = FmtS;
        end
        OpBranch: begin
          imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          fmt    = FmtB;
          pc_rel = 1'b1;
        end
        OpJal: begin
          imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          fmt    = FmtJ;
          pc_rel = 1'b1;
        end
        OpLui: begin
          imm = {instr[31:12], 12'b0};
          fmt = FmtU;
        end
        OpAuipc: begin
          imm    = {instr[31:12], 12'b0};
          fmt    = FmtU;
          pc_rel = 1'b1;
        end
        OpOp: begin
          // Register-register: legal, no immediate
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

  // JALR and everything non-relative report the fall-through PC
  assign target = pc + (pc_rel ? imm : 32'd4);

endmodule

// File: rtl/rv32i_imm_gen_pipe.sv
// Registered multi-lane RV32I immediate generator with valid/ready on both sides.
// SKID=1 adds a second entry so in_ready depends only on buffer state.
// IMM_GEN_CSR_EN (see rv32i_imm_lane) enables the CSR format decode.
module rv32i_imm_gen_pipe #(
  parameter int unsigned LANES = 1,
  parameter bit          SKID  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_instr,
  input  logic [31:0]           in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_imm,
  output logic [3*LANES-1:0]    out_fmt,
  output logic [32*LANES-1:0]   out_target,
  output logic [LANES-1:0]      out_illegal
);
  import rv32i_imm_pkg::*;

  if (LANES < 1 || LANES > MaxLanes) begin : g_bad_lanes
    $error("rv32i_imm_gen_pipe: LANES out of range");
  end

  logic [32*LANES-1:0] dec_imm, dec_target;
  logic [3*LANES-1:0]  dec_fmt;
  logic [LANES-1:0]    dec_illegal;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [31:0] lane_pc;
    assign lane_pc = in_pc + 32'(4 * k);
    rv32i_imm_lane u_lane (
      .instr   (in_instr[32*k +: 32]),
      .pc      (lane_pc),
      .imm     (dec_imm[32*k +: 32]),
      .fmt     (dec_fmt[3*k +: 3]),
      .illegal (dec_illegal[k]),
      .target  (dec_target[32*k +: 32])
    );
  end

  buf_state_e state_q, state_d;
  logic       accept, pop;
  logic       load_main, load_skid, skid_to_main;

  logic [32*LANES-1:0] imm_q, target_q, skid_imm_q, skid_target_q;
  logic [3*LANES-1:0]  fmt_q, skid_fmt_q;
  logic [LANES-1:0]    illegal_q, skid_illegal_q;

  assign out_valid = (state_q != StEmpty);
  // Without the skid entry a full buffer can only take a bundle when it is being drained
  assign in_ready  = SKID ? (state_q != StTwo) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Buffer occupancy next state and data-move controls; flush wins over everything
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            load_main = 1'b1;
          end
        end
        StOne: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = StTwo;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            state_d      = StOne;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Main (output) entry: fresh decode or promoted skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q     <= '0;
      fmt_q     <= '0;
      target_q  <= '0;
      illegal_q <= '0;
    end else if (load_main) begin
      imm_q     <= dec_imm;
      fmt_q     <= dec_fmt;
      target_q  <= dec_target;
      illegal_q <= dec_illegal;
    end else if (skid_to_main) begin
      imm_q     <= skid_imm_q;
      fmt_q     <= skid_fmt_q;
      target_q  <= skid_target_q;
      illegal_q <= skid_illegal_q;
    end
  end

  // Skid entry: holds the second bundle while the main entry is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm_q     <= '0;
      skid_fmt_q     <= '0;
      skid_target_q  <= '0;
      skid_illegal_q <= '0;
    end else if (load_skid) begin
      skid_imm_q     <= dec_imm;
      skid_fmt_q     <= dec_fmt;
      skid_target_q  <= dec_target;
      skid_illegal_q <= dec_illegal;
    end
  end

  assign out_imm     = imm_q;
  assign out_fmt     = fmt_q;
  assign out_target  = target_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_rv32i_imm_gen_pipe.sv
// Directed self-checking bench: a 2-lane skid instance and a 1-lane no-skid instance.
module tb_rv32i_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: LANES=2, SKID=1
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_instr, a_out_imm, a_out_target;
  logic [31:0] a_in_pc;
  logic [5:0]  a_out_fmt;
  logic [1:0]  a_out_illegal;

  // Instance B: LANES=1, SKID=0
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_out_imm, b_out_target, b_in_pc;
  logic [2:0]  b_out_fmt;
  logic [0:0]  b_out_illegal;

  rv32i_imm_gen_pipe #(.LANES(2), .SKID(1'b1)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (a_flush),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .in_instr    (a_in_instr),
    .in_pc       (a_in_pc),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .out_imm     (a_out_imm),
    .out_fmt     (a_out_fmt),
    .out_target  (a_out_target),
    .out_illegal (a_out_illegal)
  );

  rv32i_imm_gen_pipe #(.LANES(1), .SKID(1'b0)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (b_flush),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in_instr    (b_in_instr),
    .in_pc       (b_in_pc),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .out_imm     (b_out_imm),
    .out_fmt     (b_out_fmt),
    .out_target  (b_out_target),
    .out_illegal (b_out_illegal)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors for instance B: instr, pc, imm, fmt, target, illegal
  localparam int NV = 12;
  logic [31:0] v_instr [NV];
  logic [31:0] v_pc    [NV];
  logic [31:0] v_imm   [NV];
  logic [2:0]  v_fmt   [NV];
  logic [31:0] v_tgt   [NV];
  logic        v_ill   [NV];

  // Addi bundles with immediates 1,2,3 on both lanes, pc 0
  logic [63:0] x1, x2, x3;

  initial begin
    v_instr[0]  = 32'hFE112C23; v_pc[0]  = 32'h1000; v_imm[0]  = 32'hFFFFFFF8;
    v_fmt[0]  = 3'd2; v_tgt[0]  = 32'h1004; v_ill[0]  = 1'b0;
    v_instr[1]  = 32'h123450B7; v_pc[1]  = 32'h1000; v_imm[1]  = 32'h12345000;
    v_fmt[1]  = 3'd4; v_tgt[1]  = 32'h1004; v_ill[1]  = 1'b0;
    v_instr[2]  = 32'h00001097; v_pc[2]  = 32'h1000; v_imm[2]  = 32'h00001000;
    v_fmt[2]  = 3'd4; v_tgt[2]  = 32'h2000; v_ill[2]  = 1'b0;
    v_instr[3]  = 32'h00408067; v_pc[3]  = 32'h1000; v_imm[3]  = 32'h00000004;
    v_fmt[3]  = 3'd1; v_tgt[3]  = 32'h1004; v_ill[3]  = 1'b0;
    v_instr[4]  = 32'h002081B3; v_pc[4]  = 32'h1000; v_imm[4]  = 32'h0;
    v_fmt[4]  = 3'd0; v_tgt[4]  = 32'h1004; v_ill[4]  = 1'b0;
    v_instr[5]  = 32'h0000007F; v_pc[5]  = 32'h1000; v_imm[5]  = 32'h0;
    v_fmt[5]  = 3'd0; v_tgt[5]  = 32'h1004; v_ill[5]  = 1'b1;
    v_instr[6]  = 32'hFFF00090; v_pc[6]  = 32'h1000; v_imm[6]  = 32'h0;
    v_fmt[6]  = 3'd0; v_tgt[6]  = 32'h1004; v_ill[6]  = 1'b1;
`ifdef IMM_GEN_CSR_EN
    v_instr[7]  = 32'h3002D0F3; v_pc[7]  = 32'h1000; v_imm[7]  = 32'h00000005;
    v_fmt[7]  = 3'd6; v_tgt[7]  = 32'h1004; v_ill[7]  = 1'b0;
`else
    v_instr[7]  = 32'h3002D0F3; v_pc[7]  = 32'h1000; v_imm[7]  = 32'h00000300;
    v_fmt[7]  = 3'd1; v_tgt[7]  = 32'h1004; v_ill[7]  = 1'b0;
`endif
    v_instr[8]  = 32'h0000000F; v_pc[8]  = 32'h1000; v_imm[8]  = 32'h0;
    v_fmt[8]  = 3'd1; v_tgt[8]  = 32'h1004; v_ill[8]  = 1'b0;
    v_instr[9]  = 32'hFFC12083; v_pc[9]  = 32'h1000; v_imm[9]  = 32'hFFFFFFFC;
    v_fmt[9]  = 3'd1; v_tgt[9]  = 32'h1004; v_ill[9]  = 1'b0;
    v_instr[10] = 32'hFFDFF0EF; v_pc[10] = 32'h1000; v_imm[10] = 32'hFFFFFFFC;
    v_fmt[10] = 3'd5; v_tgt[10] = 32'h0FFC; v_ill[10] = 1'b0;
    v_instr[11] = 32'hFE000EE3; v_pc[11] = 32'h0;    v_imm[11] = 32'hFFFFFFFC;
    v_fmt[11] = 3'd3; v_tgt[11] = 32'hFFFFFFFC; v_ill[11] = 1'b0;

    x1 = {32'h00100013, 32'h00100013};
    x2 = {32'h00200013, 32'h00200013};
    x3 = {32'h00300013, 32'h00300013};

    // ---- Reset with random inputs ----
    rst_n = 1'b0;
    a_flush = 1'b0; b_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_out_ready = 1'($urandom);
      a_in_instr = {$urandom, $urandom}; a_in_pc = $urandom;
      b_in_valid = 1'b1; b_out_ready = 1'($urandom);
      b_in_instr = $urandom; b_in_pc = $urandom;
      tick();
    end
    chk("rst a out_valid", a_out_valid, 1'b0);
    chk("rst a in_ready", a_in_ready, 1'b1);
    chk("rst a imm lo", a_out_imm[31:0], 32'h0);
    chk("rst a imm hi", a_out_imm[63:32], 32'h0);
    chk("rst a target lo", a_out_target[31:0], 32'h0);
    chk("rst a fmt", a_out_fmt, 6'h0);
    chk("rst a illegal", a_out_illegal, 2'b00);
    chk("rst b out_valid", b_out_valid, 1'b0);
    chk("rst b in_ready", b_in_ready, 1'b1);
    chk("rst b imm", b_out_imm, 32'h0);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    #2 rst_n = 1'b1;
    tick();

    // ---- LANES=1 back-to-back I then B ----
    b_in_valid = 1'b1; b_in_instr = 32'hFFF00093; b_in_pc = 32'h100;
    tick();
    chk("b addi valid", b_out_valid, 1'b1);
    chk("b addi imm", b_out_imm, 32'hFFFFFFFF);
    chk("b addi fmt", b_out_fmt, 3'd1);
    chk("b addi target", b_out_target, 32'h104);
    b_in_instr = 32'hFE000EE3; b_in_pc = 32'h200;
    chk("b in_ready streaming", b_in_ready, 1'b1);
    tick();
    chk("b beq valid", b_out_valid, 1'b1);
    chk("b beq imm", b_out_imm, 32'hFFFFFFFC);
    chk("b beq fmt", b_out_fmt, 3'd3);
    chk("b beq target", b_out_target, 32'h1FC);

    // ---- Opcode table, streamed one per cycle ----
    for (int i = 0; i < NV; i++) begin
      b_in_instr = v_instr[i]; b_in_pc = v_pc[i];
      tick();
      chk($sformatf("vec%0d imm", i), b_out_imm, v_imm[i]);
      chk($sformatf("vec%0d fmt", i), b_out_fmt, v_fmt[i]);
      chk($sformatf("vec%0d target", i), b_out_target, v_tgt[i]);
      chk($sformatf("vec%0d illegal", i), b_out_illegal, v_ill[i]);
    end

    // ---- SKID=0: in_ready follows out_ready combinationally ----
    b_out_ready = 1'b0;
    #1 chk("b in_ready stalled", b_in_ready, 1'b0);
    b_out_ready = 1'b1;
    #1 chk("b in_ready released", b_in_ready, 1'b1);
    b_in_valid = 1'b0;
    tick();
    chk("b drained", b_out_valid, 1'b0);

    // ---- LANES=2 bundle: JAL + all-zero word ----
    a_in_valid = 1'b1; a_in_instr = {32'h00000000, 32'h0080006F}; a_in_pc = 32'h300;
    tick();
    chk("a jal valid", a_out_valid, 1'b1);
    chk("a lane0 imm", a_out_imm[31:0], 32'h8);
    chk("a lane0 fmt", a_out_fmt[2:0], 3'd5);
    chk("a lane0 target", a_out_target[31:0], 32'h308);
    chk("a lane0 illegal", a_out_illegal[0], 1'b0);
    chk("a lane1 illegal", a_out_illegal[1], 1'b1);
    chk("a lane1 imm", a_out_imm[63:32], 32'h0);
    chk("a lane1 fmt", a_out_fmt[5:3], 3'd0);
    chk("a lane1 target", a_out_target[63:32], 32'h308);
    a_in_valid = 1'b0;
    tick();
    chk("a drained", a_out_valid, 1'b0);

    // ---- Backpressure with skid: 3 offered, 2 taken, FIFO order ----
    a_out_ready = 1'b0; a_in_pc = 32'h0;
    a_in_valid = 1'b1; a_in_instr = x1;
    tick();
    chk("bp one in_ready", a_in_ready, 1'b1);
    a_in_instr = x2;
    tick();
    chk("bp two in_ready", a_in_ready, 1'b0);
    chk("bp two head", a_out_imm[31:0], 32'd1);
    a_in_instr = x3;
    tick();
    chk("bp hold valid", a_out_valid, 1'b1);
    chk("bp hold head", a_out_imm[31:0], 32'd1);
    chk("bp hold lane1", a_out_imm[63:32], 32'd1);
    a_out_ready = 1'b1;
    tick();
    chk("bp pop1 next", a_out_imm[31:0], 32'd2);
    chk("bp pop1 in_ready", a_in_ready, 1'b1);
    tick();
    chk("bp pop2 next", a_out_imm[31:0], 32'd3);
    chk("bp pop2 valid", a_out_valid, 1'b1);
    a_in_valid = 1'b0;
    tick();
    chk("bp drained", a_out_valid, 1'b0);

    // ---- Flush in TWO with an offered bundle ----
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = x1;
    tick();
    a_in_instr = x2;
    tick();
    a_flush = 1'b1; a_in_instr = x3;
    tick();
    chk("flush two valid", a_out_valid, 1'b0);
    chk("flush two in_ready", a_in_ready, 1'b1);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    chk("flush two stays empty", a_out_valid, 1'b0);

    // ---- Flush in ONE while a bundle is accepted ----
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = x1;
    tick();
    a_flush = 1'b1; a_in_instr = x3;
    tick();
    chk("flush one valid", a_out_valid, 1'b0);
    a_flush = 1'b0; a_in_valid = 1'b0;
    tick();
    chk("flush one dropped", a_out_valid, 1'b0);
    a_in_valid = 1'b1; a_in_instr = x2;
    tick();
    chk("post flush imm", a_out_imm[31:0], 32'd2);
    a_in_valid = 1'b0;

    // ---- Asynchronous reset mid-transfer ----
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", a_out_valid, 1'b0);
    chk("async rst in_ready", a_in_ready, 1'b1);
    chk("async rst imm", a_out_imm[31:0], 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("after rst empty", a_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32i_imm_gen_pipe.md
Name: rv32i_imm_gen_pipe

Overview:
Registered, multi-lane successor to the combinational immediate generator, placed between fetch and decode/issue.
- Accepts a bundle of LANES instructions with the PC of lane 0.
- For each lane, produces the sign-extended immediate, a format code, an illegal-opcode flag and a PC-relative target.
- Decoupled from both neighbours by a valid/ready handshake, with an optional skid entry so `in_ready` depends only on state.

Parameters:
LANES, 1, instructions per bundle (legal range 1..4); lane k sits at PC = in_pc + 4k.
SKID, 1, 1 = two-entry buffer (main + skid); 0 = single entry.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all buffered bundles
in_valid  input  1  upstream bundle valid
in_ready  output  1  block can accept a bundle this cycle
in_instr  input  32*LANES  lane k = bits [32k+31:32k]
in_pc  input  32  PC of lane 0
out_valid  output  1  output bundle valid
out_ready  input  1  downstream accepts this cycle
out_imm  output  32*LANES  immediate per lane
out_fmt  output  3*LANES  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR
out_target  output  32*LANES  PC-relative target per lane
out_illegal  output  LANES  unrecognised encoding per lane

Behaviour:
- Reset (rst_n low, asynchronous): buffer EMPTY; out_valid=0; out_imm, out_fmt, out_target, out_illegal all 0; in_ready=1.
- Decode per lane, in the cycle of acceptance; the result is registered.
  - I format, imm = sext(instr[31:20]): opcodes 0010011, 0000011, 1100111, 0001111, 1110011.
  - S format, imm = sext({instr[31:25], instr[11:7]}): opcode 0100011.
  - B format: opcode 1100011; J format: opcode 1101111. Standard scrambled encodings, bit0=0.
  - U format, imm = {instr[31:12], 12'b0}: opcodes 0110111, 0010111.
  - NONE format, imm 0, legal: opcode 0110011.
  - Any other opcode, or instr[1:0] != 2'b11: imm 0, fmt NONE, illegal=1.
- Target arithmetic, modulo 2^32:
  - B, J and AUIPC: target = pc_k + imm.
  - All others, including JALR: target = pc_k + 4.
- Latency: 1 cycle from acceptance (in_valid && in_ready) to out_valid. Throughput is 1 bundle/cycle while out_ready=1.
- Buffer FSM, SKID=1. States EMPTY, ONE, TWO; `in_ready` = (state != TWO).
  - EMPTY + accept -> ONE.
  - ONE + accept + no pop -> TWO (new bundle into skid).
  - ONE + pop + no accept -> EMPTY.
  - ONE + accept + pop -> ONE (main replaced).
  - TWO + pop -> ONE (skid moves into main).
  - A pop is out_valid && out_ready.
- SKID=0: states EMPTY and ONE only; in_ready = !out_valid || out_ready, combinational.
- Outputs hold stable while out_valid && !out_ready.
- Order is strict FIFO; no bundle is dropped or duplicated.
- Flush has priority over accept and pop:
  - Next state is EMPTY and out_valid=0; the input that cycle is discarded.
  - Output data registers may retain stale values.
- Simultaneous accept and pop in ONE is legal with no bubble.
- Reset asserted mid-transfer returns to EMPTY immediately.

Optional Feature:
Macro IMM_GEN_CSR_EN.
- Defined: opcode 1110011 with funct3[2]=1 gives fmt CSR (6) and imm = zero-extended instr[19:15]. Other SYSTEM encodings remain I format.
- Undefined: every 1110011 encoding is I format; code 6 is never produced.

Decomposition:
- Package rv32i_imm_pkg holds:
  - opcode localparams
  - the 3-bit format codes
  - the LANES upper bound
- One natural sub-module: rv32i_imm_lane, the combinational per-lane decoder.
  - Inputs: instr, pc.
  - Outputs: imm, fmt, illegal, target.
  - Instantiated LANES times in a generate loop; the top level holds only the buffer FSM and registers.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, in_ready=1, all outputs 0.
- LANES=1, I and B formats, back-to-back:
  - 0xFFF00093 at pc 0x100 -> next cycle imm 0xFFFFFFFF, fmt 1, target 0x104.
  - 0xFE000EE3 at pc 0x200 -> imm 0xFFFFFFFC, fmt 3, target 0x1FC.
- LANES=2, bundle {0x0080006F, 0x00000000} at pc 0x300:
  - lane0 -> imm 8, fmt 5, target 0x308.
  - lane1 -> illegal=1, imm 0.
- Backpressure, SKID=1: out_ready=0, offer 3 bundles -> 2 accepted, in_ready=0 after the second. Then raise out_ready -> 3 bundles emitted in order, none lost or repeated.
- Flush in state TWO, with in_valid=1 the same cycle -> out_valid=0 next cycle, in_ready=1, and the offered bundle never appears.
- CSR: 0x3002D0F3 -> with IMM_GEN_CSR_EN, imm 5, fmt 6; without it, imm 0x300, fmt 1.
